// File: rtl/btn_debounce.sv
// Multi-channel push-button debouncer: 2-FF synchronizer plus per-channel debounce FSM.
// Define LONG_PRESS_EN to add a per-channel long-press detector driving o_long.
module btn_debounce #(
  parameter int unsigned N_BTN           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1250000,
  parameter int unsigned LONG_CYCLES     = 125000000
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] o_level,
  output logic [N_BTN-1:0] o_press,
  output logic [N_BTN-1:0] o_release,
  output logic [N_BTN-1:0] o_toggle,
  output logic [N_BTN-1:0] o_long
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;

  // Two-stage synchronizer; sync2 is the only view of the raw buttons
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             press_nxt;
    logic             release_nxt;
    logic             level_q, press_q, release_q, toggle_q;

    // Counter saturates at CNT_LAST: the compare ends counting before any wrap
    always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      case (state)
        RELEASED: begin
          if (sync2[i]) begin
            state_nxt = PRESS_WAIT;
            cnt_nxt   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync2[i]) begin
            state_nxt = RELEASED;
          end else if (cnt == CNT_LAST) begin
            state_nxt = PRESSED;
            press_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!sync2[i]) begin
            state_nxt = RELEASE_WAIT;
            cnt_nxt   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (sync2[i]) begin
            state_nxt = PRESSED;
          end else if (cnt == CNT_LAST) begin
            state_nxt   = RELEASED;
            release_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: state_nxt = RELEASED;
      endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
        state     <= RELEASED;
        cnt       <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        toggle_q  <= 1'b0;
      end else begin
        state     <= state_nxt;
        cnt       <= cnt_nxt;
        level_q   <= (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
        press_q   <= press_nxt;
        release_q <= release_nxt;
        toggle_q  <= toggle_q ^ press_nxt;
      end
    end

    assign o_level[i]   = level_q;
    assign o_press[i]   = press_q;
    assign o_release[i] = release_q;
    assign o_toggle[i]  = toggle_q;

`ifdef LONG_PRESS_EN
    localparam int unsigned       HOLD_W   = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

    logic [HOLD_W-1:0] hold, hold_nxt;
    logic              long_nxt;
    logic              long_q;

    // Hold counter restarts on each accepted press and sticks at HOLD_MAX, so one pulse per press
    always_comb begin
      hold_nxt = hold;
      long_nxt = 1'b0;
      if (press_nxt) begin
        hold_nxt = '0;
      end else if (((state == PRESSED) || (state == RELEASE_WAIT)) && (hold != HOLD_MAX)) begin
        hold_nxt = hold + 1'b1;
        long_nxt = (hold_nxt == HOLD_MAX);
      end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
        hold   <= '0;
        long_q <= 1'b0;
      end else begin
        hold   <= hold_nxt;
        long_q <= long_nxt;
      end
    end

    assign o_long[i] = long_q;
`else
    assign o_long[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Randomized scoreboard bench for btn_debounce; reference model counts run lengths of the synced sample.
module tb_btn_debounce;

  localparam int N = 2;
  localparam int D = 4;
  localparam int L = 20;

  logic         sysclk = 1'b0;
  logic         rst_n  = 1'b0;
  logic [N-1:0] btn    = '0;
  logic [N-1:0] o_level, o_press, o_release, o_toggle, o_long;

  btn_debounce #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L)
  ) dut (
    .sysclk   (sysclk),
    .rst_n    (rst_n),
    .btn      (btn),
    .o_level  (o_level),
    .o_press  (o_press),
    .o_release(o_release),
    .o_toggle (o_toggle),
    .o_long   (o_long)
  );

  always #5 sysclk = ~sysclk;

  typedef struct packed {
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] tog;
    logic [N-1:0] lng;
  } obs_t;

  obs_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: sync pipeline, accepted level, mismatch run length, hold time
  logic [N-1:0] p1, p2;
  bit           lvl[N];
  bit           tg[N];
  int           run[N];
  int           hold[N];
  obs_t         exp_o;

  task automatic model_reset();
    p1 = '0;
    p2 = '0;
    for (int c = 0; c < N; c++) begin
      lvl[c] = 0; tg[c] = 0; run[c] = 0; hold[c] = 0;
    end
    exp_o = '0;
  endtask

  // An edge is accepted once the sample has disagreed with the level for D+1 straight clocks
  task automatic model_step();
    logic s;
    exp_o = '0;
    for (int c = 0; c < N; c++) begin
      s = p2[c];
      if (s != lvl[c]) run[c]++;
      else run[c] = 0;
`ifdef LONG_PRESS_EN
      if (lvl[c] && hold[c] < L) begin
        hold[c]++;
        if (hold[c] == L) exp_o.lng[c] = 1'b1;
      end
`endif
      if (run[c] == D + 1) begin
        run[c] = 0;
        lvl[c] = !lvl[c];
        if (lvl[c]) begin
          exp_o.press[c] = 1'b1;
          tg[c]          = !tg[c];
          hold[c]        = 0;
        end else begin
          exp_o.rel[c] = 1'b1;
        end
      end
      exp_o.level[c] = lvl[c];
      exp_o.tog[c]   = tg[c];
    end
    p2 = p1;
    p1 = btn;
  endtask

  // Model advances on each rising edge and queues the outputs the DUT must show next
  always @(posedge sysclk) begin
    #1;
    if (!rst_n) model_reset();
    else model_step();
    q.push_back(exp_o);
  end

  // Monitor compares on the falling edge, independent of stimulus
  always @(negedge sysclk) begin
    obs_t e, g;
    if (q.size() > 0) begin
      e = q.pop_front();
      g = '{o_level, o_press, o_release, o_toggle, o_long};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got lvl=%b prs=%b rel=%b tog=%b lng=%b exp lvl=%b prs=%b rel=%b tog=%b lng=%b",
                 $time, g.level, g.press, g.rel, g.tog, g.lng, e.level, e.press, e.rel, e.tog, e.lng);
      end
    end
  end

  task automatic tick(input logic [N-1:0] b);
    @(negedge sysclk);
    #2;
    btn = b;
  endtask

  task automatic hold_btn(input logic [N-1:0] b, input int n);
    for (int k = 0; k < n; k++) tick(b);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge sysclk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_level, o_press, o_release, o_toggle, o_long} !== '0) begin
      errors++;
      $display("FAIL reset_clear t=%0t got %b exp 0", $time,
               {o_level, o_press, o_release, o_toggle, o_long});
    end
    repeat (cycles) @(negedge sysclk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] r;
    int           len;
    model_reset();
    repeat (3) @(negedge sysclk);
    #2;
    rst_n = 1'b1;

    hold_btn(2'b01, 20);
    hold_btn(2'b00, 20);
    for (int k = 0; k < 10; k++) begin
      hold_btn(2'b01, 1);
      hold_btn(2'b00, 2);
    end
    hold_btn(2'b00, 10);
    for (int k = 0; k < 2; k++) begin
      hold_btn(2'b10, 12);
      hold_btn(2'b00, 12);
    end
    hold_btn(2'b11, 12);
    hold_btn(2'b00, 12);

    // Reset while channel 0 is mid-debounce, button kept held through release
    hold_btn(2'b01, 5);
    do_reset(3);
    hold_btn(2'b01, 15);
    hold_btn(2'b00, 15);

    hold_btn(2'b01, 60);
    hold_btn(2'b00, 15);

    for (int k = 0; k < 400; k++) begin
      r   = N'($urandom_range(0, 3));
      len = (($urandom % 3) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 30));
      hold_btn(r, len);
      if (($urandom % 50) == 0) do_reset(int'($urandom_range(1, 3)));
    end
    hold_btn(2'b00, 20);
    repeat (2) @(negedge sysclk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter N_BTN, default 2: number of independent button channels, 1..8.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1250000: stable-sample count required to accept an edge (10 ms at 125 MHz); legal range 1..2^24-1.
REQ-003 SHALL have parameter LONG_CYCLES, default 125000000: hold count for long-press (1 s at 125 MHz); used only with LONG_PRESS_EN.
REQ-004 SHALL have port sysclk, input, 1: single system clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port btn, input, N_BTN: raw asynchronous button levels, 1 = pressed.
REQ-007 SHALL have port o_level, output, N_BTN: debounced level per channel.
REQ-008 SHALL have port o_press, output, N_BTN: one-cycle pulse on each accepted press.
REQ-009 SHALL have port o_release, output, N_BTN: one-cycle pulse on each accepted release.
REQ-010 SHALL have port o_toggle, output, N_BTN: per-channel on/off flag, inverted on every o_press.
REQ-011 SHALL have port o_long, output, N_BTN: one-cycle long-press pulse; constant 0 when LONG_PRESS_EN is undefined.

Function
REQ-012 Each channel SHALL pass btn through a 2-FF synchronizer; the second stage is the sample s; no other logic uses raw btn.
REQ-013 Each channel SHALL run an independent FSM with states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT and a counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-014 RELEASED: s=1 -> PRESS_WAIT, counter cleared; s=0 -> stay.
REQ-015 PRESS_WAIT: s=0 -> RELEASED, no pulse (glitch rejected); s=1 -> counter+1; -> PRESSED on the edge where s has been 1 for DEBOUNCE_CYCLES consecutive PRESS_WAIT cycles.
REQ-016 PRESSED: s=0 -> RELEASE_WAIT, counter cleared; s=1 -> stay.
REQ-017 RELEASE_WAIT: s=1 -> PRESSED, no pulse; s=0 for DEBOUNCE_CYCLES consecutive cycles -> RELEASED.
REQ-018 o_level SHALL be 1 in PRESSED and RELEASE_WAIT, 0 otherwise.
REQ-019 o_press SHALL be high exactly the one cycle following entry to PRESSED from PRESS_WAIT; o_release the one cycle following entry to RELEASED from RELEASE_WAIT.
REQ-020 o_toggle SHALL invert on the same edge that asserts o_press.
REQ-021 Latency: btn rising before edge 1 and held stable SHALL assert o_press after edge 3+DEBOUNCE_CYCLES; release latency identical.
REQ-022 Counters SHALL never wrap; the comparison terminates counting.
REQ-023 Channels SHALL be fully independent; simultaneous events on several channels produce simultaneous pulses.
REQ-024 All outputs SHALL be registered; no combinational path from btn to any output.

Reset
REQ-025 rst_n=0 SHALL immediately clear synchronizers, counters, o_level, o_press, o_release, o_toggle, o_long, and force RELEASED, regardless of in-progress debounce.
REQ-026 A button held through rst_n deassertion SHALL be treated as a fresh press, with o_press after REQ-021 latency.

Configuration
REQ-027 Macro LONG_PRESS_EN defined: a saturating per-channel hold counter (width clog2(LONG_CYCLES+1)) SHALL count cycles in PRESSED/RELEASE_WAIT, clear on entry to PRESSED from PRESS_WAIT, and pulse o_long for one cycle when it reaches LONG_CYCLES, at most once per press.
REQ-028 Macro LONG_PRESS_EN undefined: hold counter SHALL not be instantiated; o_long SHALL be tied to 0.

Verification (N_BTN=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
REQ-029 btn[0] 0->1 before edge 1, held -> o_press[0] high only the cycle after edge 7, o_level[0]=1, o_toggle[0]=1; btn[1] outputs stay 0.
REQ-030 btn[0] 1-cycle pulses every 3 cycles for 30 cycles -> no o_press, o_level stays 0.
REQ-031 Two full press/release cycles on btn[1] -> two o_press, two o_release pulses, o_toggle[1] 0->1->0.
REQ-032 Both buttons rise on the same cycle -> o_press=2'b11 on the same cycle.
REQ-033 rst_n low during PRESS_WAIT counter=2 -> all outputs 0 immediately; button still held -> o_press 7 cycles after rst_n release.
REQ-034 LONG_PRESS_EN defined, btn[0] held 40 cycles past o_press -> exactly one o_long[0] pulse, 20 cycles after o_press; undefined -> o_long stays 0.
